// File: rtl/mem_write_checker_pkg.sv
// mem_write_checker_pkg: shared state/fail-code types and index-width helper
package mem_write_checker_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
  typedef enum logic [1:0] {FC_NONE, FC_ADDR_UNEXPECTED, FC_DATA_MISMATCH, FC_TIMEOUT} fail_code_t;
  localparam int FC_W = 2;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_write_checker_exp_table.sv
// exp_table: expected-store storage, matched bitmap and ordered/unordered lookup
module exp_table
  import mem_write_checker_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int N = 4,
  parameter int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [AW-1:0] wadr,
  input  logic [DW-1:0] wdata,
  input  logic          mark,
  input  logic [IW-1:0] midx,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] data,
  input  logic [IW-1:0] sel,
  output logic          hit,
  output logic [IW-1:0] hit_idx,
  output logic          ahit,
  output logic [IW-1:0] ahit_idx,
  output logic          sel_adr_eq,
  output logic          sel_data_eq
);
  logic [AW-1:0] ea [N];
  logic [DW-1:0] ed [N];
  logic [N-1:0] matched;
  always_ff @(posedge clk) begin
    if (we && 32'(widx) < N) begin
      ea[widx] <= wadr;
      ed[widx] <= wdata;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) matched <= '0;
    else if (mark) matched[midx] <= 1'b1;
  end
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    ahit = 1'b0;
    ahit_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!matched[i] && ea[i] == adr) begin
        ahit = 1'b1;
        ahit_idx = IW'(i);
        if (ed[i] == data) begin
          hit = 1'b1;
          hit_idx = IW'(i);
        end
      end
    end
  end
  assign sel_adr_eq = ea[sel] == adr;
  assign sel_data_eq = ed[sel] == data;
endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: programmable expected-store monitor for the data-memory write port
module mem_write_checker
  import mem_write_checker_pkg::*;
#(
  parameter int          DW = 32,
  parameter int          AW = 32,
  parameter int          N_EXP = 4,
  parameter bit          ORDERED = 1'b1,
  parameter bit          IGNORE_EN = 1'b1,
  parameter int unsigned IGNORE_ADR = 80,
  parameter int          TIMEOUT = 1000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         exp_we,
  input  logic [idx_w(N_EXP)-1:0]      exp_idx,
  input  logic [AW-1:0]                exp_adr,
  input  logic [DW-1:0]                exp_data,
  input  logic                         start,
  input  logic                         memwrite,
  input  logic [AW-1:0]                dataadr,
  input  logic [DW-1:0]                writedata,
  output logic                         done,
  output logic                         pass,
  output logic [FC_W-1:0]              fail_code,
  output logic [idx_w(N_EXP)-1:0]      fail_idx,
  output logic [AW-1:0]                fail_adr,
  output logic [DW-1:0]                fail_data,
  output logic [$clog2(N_EXP+1)-1:0]   match_count,
  output logic [$clog2(TIMEOUT+1)-1:0] cycles
);
  localparam int IW = idx_w(N_EXP);
  localparam int MW = $clog2(N_EXP + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state;
  fail_code_t ecode;
  logic ign, chk, ok, mark, last, tmo, hit, ahit, sa, sd;
  logic [IW-1:0] sel, hidx, aidx, midx, eidx;
  assign sel = IW'(match_count);
  assign ign = IGNORE_EN && dataadr == AW'(IGNORE_ADR);
  assign chk = state == RUN && memwrite && !ign;
  assign ok = ORDERED ? sa && sd : hit;
  assign mark = chk && ok;
  assign midx = ORDERED ? sel : hidx;
  assign ecode = (ORDERED ? sa : ahit) ? FC_DATA_MISMATCH : FC_ADDR_UNEXPECTED;
  assign eidx = ORDERED ? sel : ahit ? aidx : '0;
  assign last = match_count == MW'(N_EXP - 1);
  assign tmo = cycles == CW'(TIMEOUT - 1);
  exp_table #(.AW(AW), .DW(DW), .N(N_EXP), .IW(IW)) u_table (
    .clk(clk),
    .reset(reset),
    .we(exp_we && state == IDLE),
    .widx(exp_idx),
    .wadr(exp_adr),
    .wdata(exp_data),
    .mark(mark),
    .midx(midx),
    .adr(dataadr),
    .data(writedata),
    .sel(sel),
    .hit(hit),
    .hit_idx(hidx),
    .ahit(ahit),
    .ahit_idx(aidx),
    .sel_adr_eq(sa),
    .sel_data_eq(sd)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done <= 1'b0;
      pass <= 1'b0;
      fail_code <= FC_NONE;
      fail_idx <= '0;
      fail_adr <= '0;
      fail_data <= '0;
      match_count <= '0;
      cycles <= '0;
    end else if (state == IDLE) begin
      if (start) state <= RUN;
    end else if (state == RUN) begin
      match_count <= match_count + MW'(mark);
      if (mark && last) begin
        state <= PASS;
        done <= 1'b1;
        pass <= 1'b1;
      end else if (chk && !ok) begin
        state <= FAIL;
        done <= 1'b1;
        fail_code <= ecode;
        fail_idx <= eidx;
        fail_adr <= dataadr;
        fail_data <= writedata;
      end else if (tmo) begin
        state <= FAIL;
        done <= 1'b1;
        fail_code <= FC_TIMEOUT;
        fail_idx <= sel + IW'(mark);
      end else begin
        cycles <= cycles + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: ordered and unordered checkers driven side by side against a store-level model
module tb_mem_write_checker;
  localparam int N = 2;
  localparam int TO = 20;
  logic clk = 1'b0;
  logic reset = 1'b0, exp_we = 1'b0, exp_idx = 1'b0, start = 1'b0, memwrite = 1'b0;
  logic [31:0] exp_adr = '0, exp_data = '0, dataadr = '0, writedata = '0;
  logic o_done, o_pass, u_done, u_pass;
  logic [1:0] o_fail_code, u_fail_code, o_match_count, u_match_count;
  logic [0:0] o_fail_idx, u_fail_idx;
  logic [31:0] o_fail_adr, u_fail_adr, o_fail_data, u_fail_data;
  logic [4:0] o_cycles, u_cycles;
  int checks = 0;
  int errors = 0;
  int st[2], mc[2], cy[2], code[2], fidx[2];
  logic [31:0] fadr[2], fdat[2], tadr[2][N], tdat[2][N];
  bit mt[2][N];
  always #5 clk = ~clk;
  mem_write_checker #(.N_EXP(N), .ORDERED(1'b1), .TIMEOUT(TO)) dut_o (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_adr(exp_adr),
    .exp_data(exp_data), .start(start), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .done(o_done), .pass(o_pass), .fail_code(o_fail_code),
    .fail_idx(o_fail_idx), .fail_adr(o_fail_adr), .fail_data(o_fail_data),
    .match_count(o_match_count), .cycles(o_cycles)
  );
  mem_write_checker #(.N_EXP(N), .ORDERED(1'b0), .TIMEOUT(TO)) dut_u (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_adr(exp_adr),
    .exp_data(exp_data), .start(start), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .done(u_done), .pass(u_pass), .fail_code(u_fail_code),
    .fail_idx(u_fail_idx), .fail_adr(u_fail_adr), .fail_data(u_fail_data),
    .match_count(u_match_count), .cycles(u_cycles)
  );
  task automatic upd(input int m);
    int hit = -1;
    int ahit = -1;
    bit store = memwrite && dataadr != 32'd80;
    if (reset) begin
      st[m] = 0; mc[m] = 0; cy[m] = 0; code[m] = 0; fidx[m] = 0; fadr[m] = 0; fdat[m] = 0;
      for (int j = 0; j < N; j++) mt[m][j] = 0;
      return;
    end
    if (st[m] == 0) begin
      if (exp_we) begin
        tadr[m][exp_idx] = exp_adr;
        tdat[m][exp_idx] = exp_data;
      end
      if (start) st[m] = 1;
      return;
    end
    if (st[m] != 1) return;
    if (store)
      for (int j = 0; j < N; j++)
        if ((m == 0 ? j == mc[m] : !mt[m][j]) && tadr[m][j] == dataadr) begin
          if (ahit < 0) ahit = j;
          if (hit < 0 && tdat[m][j] == writedata) hit = j;
        end
    if (hit >= 0) begin
      mt[m][hit] = 1;
      mc[m]++;
      if (mc[m] == N) begin
        st[m] = 2;
        return;
      end
    end else if (store) begin
      st[m] = 3;
      code[m] = ahit >= 0 ? 2 : 1;
      fidx[m] = m == 0 ? mc[m] : (ahit >= 0 ? ahit : 0);
      fadr[m] = dataadr;
      fdat[m] = writedata;
      return;
    end
    if (cy[m] == TO - 1) begin
      st[m] = 3;
      code[m] = 3;
      fidx[m] = mc[m] < N ? mc[m] : N - 1;
      return;
    end
    cy[m]++;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      string p = m == 0 ? "ord" : "unord";
      chk({p, ".done"}, m == 0 ? o_done : u_done, 64'(st[m] >= 2));
      chk({p, ".pass"}, m == 0 ? o_pass : u_pass, 64'(st[m] == 2));
      chk({p, ".fail_code"}, m == 0 ? o_fail_code : u_fail_code, 64'(code[m]));
      chk({p, ".fail_idx"}, m == 0 ? o_fail_idx : u_fail_idx, 64'(fidx[m]));
      chk({p, ".fail_adr"}, m == 0 ? o_fail_adr : u_fail_adr, 64'(fadr[m]));
      chk({p, ".fail_data"}, m == 0 ? o_fail_data : u_fail_data, 64'(fdat[m]));
      chk({p, ".match_count"}, m == 0 ? o_match_count : u_match_count, 64'(mc[m]));
      chk({p, ".cycles"}, m == 0 ? o_cycles : u_cycles, 64'(cy[m]));
    end
  endtask
  task automatic tick();
    @(posedge clk);
    upd(0);
    upd(1);
    #1;
    check_all();
    reset = 1'b0;
    start = 1'b0;
    memwrite = 1'b0;
    exp_we = 1'b0;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1;
    dataadr = a;
    writedata = d;
    tick();
  endtask
  task automatic wr(input logic i, input logic [31:0] a, input logic [31:0] d);
    exp_we = 1'b1;
    exp_idx = i;
    exp_adr = a;
    exp_data = d;
    tick();
  endtask
  task automatic rst();
    reset = 1'b1;
    tick();
  endtask
  task automatic go();
    start = 1'b1;
    tick();
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  initial begin
    rst();
    chk("reset.done", o_done, 0);
    chk("reset.fail_code", u_fail_code, 0);
    chk("reset.match_count", o_match_count, 0);
    wr(0, 84, 7);
    wr(1, 88, 9);
    go();
    store(80, 3);
    chk("ignored.match_count", o_match_count, 0);
    store(84, 7);
    store(88, 9);
    chk("inorder.ord.pass", o_pass, 1);
    chk("inorder.ord.match_count", o_match_count, 2);
    chk("inorder.unord.pass", u_pass, 1);
    rst();
    go();
    store(88, 9);
    chk("swap.ord.fail_code", o_fail_code, 1);
    chk("swap.ord.fail_idx", o_fail_idx, 0);
    chk("swap.ord.fail_adr", o_fail_adr, 88);
    chk("swap.unord.done", u_done, 0);
    store(84, 7);
    chk("swap.unord.pass", u_pass, 1);
    rst();
    go();
    store(84, 7);
    store(84, 5);
    chk("rematch.unord.fail_code", u_fail_code, 1);
    chk("rematch.unord.fail_idx", u_fail_idx, 0);
    chk("rematch.ord.fail_idx", o_fail_idx, 1);
    rst();
    go();
    store(88, 1);
    chk("baddata.unord.fail_code", u_fail_code, 2);
    chk("baddata.unord.fail_idx", u_fail_idx, 1);
    chk("baddata.ord.fail_code", o_fail_code, 1);
    rst();
    go();
    idle(19);
    chk("timeout.early.done", o_done, 0);
    idle(1);
    chk("timeout.done", o_done, 1);
    chk("timeout.fail_code", o_fail_code, 3);
    chk("timeout.cycles", u_cycles, 19);
    rst();
    go();
    store(84, 7);
    idle(18);
    store(88, 9);
    chk("lastcycle.ord.pass", o_pass, 1);
    chk("lastcycle.unord.pass", u_pass, 1);
    rst();
    go();
    store(84, 7);
    rst();
    chk("midreset.match_count", o_match_count, 0);
    chk("midreset.cycles", u_cycles, 0);
    go();
    store(84, 7);
    store(88, 9);
    chk("rerun.pass", o_pass, 1);
    rst();
    go();
    exp_we = 1'b1;
    exp_idx = 1'b0;
    exp_adr = 100;
    exp_data = 1;
    start = 1'b1;
    tick();
    store(84, 7);
    store(88, 9);
    chk("runwrite.ord.pass", o_pass, 1);
    chk("runwrite.unord.pass", u_pass, 1);
    for (int r = 0; r < 40; r++) begin
      rst();
      for (int e = 0; e < N; e++)
        wr(e[0], 84 + 4 * $urandom_range(0, 2), $urandom_range(0, 1) ? 7 : 9);
      go();
      for (int c = 0; c < 24; c++) begin
        memwrite = $urandom_range(0, 2) != 0;
        dataadr = 80 + 4 * $urandom_range(0, 3);
        writedata = $urandom_range(0, 1) ? 7 : 9;
        exp_we = $urandom_range(0, 7) == 0;
        exp_idx = 1'($urandom_range(0, 1));
        exp_adr = 84;
        exp_data = 7;
        start = $urandom_range(0, 7) == 0;
        reset = $urandom_range(0, 59) == 0;
        tick();
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
